// File: rtl/cell_xor_sequencer.sv
// Sequencer for the 25-cell bit memory. It bulk-loads a line, XORs each cell with a key
// through a read-modify-write walk, then reads every cell back to build the result.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start_i; line/key captured on acceptance
// S_INIT   | one-cycle bulk-load strobe, memory loads mem_line_o
// S_READ   | read cell idx_q, latch the bit into bit_q
// S_WRITE  | write bit_q ^ key[idx_q] back, remember it in expect_q
// S_VERIFY | read cell idx_q back into result, flag any mismatch
// S_DONE   | one-cycle completion pulse
module cell_xor_sequencer #(
  parameter int SIZE    = 5,
  parameter int MEMSIZE = 25
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [MEMSIZE-1:0] line_in_i,
  input  logic [MEMSIZE-1:0] key_in_i,
  input  logic               mem_out_i,
  output logic               mem_init_o,
  output logic [MEMSIZE-1:0] mem_line_o,
  output logic [SIZE-1:0]    mem_index_o,
  output logic               mem_val_o,
  output logic               mem_write_o,
  output logic               mem_read_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [MEMSIZE-1:0] result_o,
  output logic               error_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_VERIFY = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(MEMSIZE - 1);
  localparam logic [SIZE-1:0] IDX_ONE  = SIZE'(1);

  state_t             state_q,  state_d;
  logic [SIZE-1:0]    idx_q,    idx_d;
  logic [MEMSIZE-1:0] line_q,   line_d;
  logic [MEMSIZE-1:0] key_q,    key_d;
  logic [MEMSIZE-1:0] expect_q, expect_d;
  logic [MEMSIZE-1:0] result_q, result_d;
  logic               error_q,  error_d;
  logic               bit_q,    bit_d;
  logic               wval;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      line_q   <= '0;
      key_q    <= '0;
      expect_q <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      line_q   <= line_d;
      key_q    <= key_d;
      expect_q <= expect_d;
      result_q <= result_d;
      error_q  <= error_d;
      bit_q    <= bit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_d      = line_q;
    key_d       = key_q;
    expect_d    = expect_q;
    result_d    = result_q;
    error_d     = error_q;
    bit_d       = bit_q;
    wval        = bit_q ^ key_q[idx_q];
    mem_init_o  = 1'b0;
    mem_index_o = '0;
    mem_val_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          line_d   = line_in_i;
          key_d    = key_in_i;
          result_d = '0;
          error_d  = 1'b0;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        mem_init_o = 1'b1;
        idx_d      = '0;
        state_d    = S_READ;
      end
      S_READ: begin
        mem_index_o = idx_q;
        mem_read_o  = 1'b1;
        bit_d       = mem_out_i;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        mem_index_o     = idx_q;
        mem_write_o     = 1'b1;
        mem_val_o       = wval;
        expect_d[idx_q] = wval;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_VERIFY;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_READ;
        end
      end
      S_VERIFY: begin
        mem_index_o     = idx_q;
        mem_read_o      = 1'b1;
        result_d[idx_q] = mem_out_i;
        if (mem_out_i != expect_q[idx_q]) begin
          error_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // busy spans INIT through the last VERIFY cycle; DONE is deliberately excluded
  assign busy_o     = (state_q == S_INIT) || (state_q == S_READ) ||
                      (state_q == S_WRITE) || (state_q == S_VERIFY);
  assign mem_line_o = line_q;
  assign result_o   = result_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_cell_xor_sequencer.sv
// Scoreboard bench for cell_xor_sequencer with a behavioural 25-cell bit memory.
// Stimulus pushes hand-computed expectations; the monitor checks them at each done pulse.
module tb_cell_xor_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [24:0] line_in_i, key_in_i;
  logic        mem_out_i;
  logic        mem_init_o, mem_val_o, mem_write_o, mem_read_o;
  logic [24:0] mem_line_o, result_o;
  logic [4:0]  mem_index_o;
  logic        busy_o, done_o, error_o;

  cell_xor_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .line_in_i(line_in_i), .key_in_i(key_in_i), .mem_out_i(mem_out_i),
    .mem_init_o(mem_init_o), .mem_line_o(mem_line_o), .mem_index_o(mem_index_o),
    .mem_val_o(mem_val_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [24:0] res;
    logic        err;
    logic [24:0] mem;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int init_cyc = 0;
  int n_init = 0, n_wr = 0, n_rd = 0, n_ord = 0, n_excl = 0, n_idx = 0;
  logic        inject = 1'b0;
  logic [24:0] mem_q = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // memory model; contents survive a sequencer reset
  always @(posedge clk_i) begin
    if (mem_init_o) mem_q <= mem_line_o;
    else if (mem_write_o && mem_index_o < 5'd25) mem_q[mem_index_o] <= mem_val_o;
  end

  // n_wr reaches 25 only in the verify pass, so injection hits verify reads only
  assign mem_out_i = mem_read_o && (mem_index_o < 5'd25) &&
                     (mem_q[mem_index_o] ^ (inject && n_wr == 25 && mem_index_o == 5'd7));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!busy_o && !done_o) begin
      n_init = 0; n_wr = 0; n_rd = 0; n_ord = 0; n_excl = 0; n_idx = 0;
    end else begin
      if (mem_init_o) begin
        n_init++;
        init_cyc = cyc;
      end
      if (int'(mem_init_o) + int'(mem_write_o) + int'(mem_read_o) > 1) n_excl++;
      if (mem_index_o > 5'd24) n_idx++;
      if (mem_write_o) begin
        if (int'(mem_index_o) != n_wr) n_ord++;
        n_wr++;
      end
      if (mem_read_o) n_rd++;
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result_o), 32'(e.res));
          chk("error", 32'(error_o), 32'(e.err));
          chk("mem_image", 32'(mem_q), 32'(e.mem));
          chk("latency_init_to_done", 32'(cyc - init_cyc), 32'd76);
          chk("init_pulses", 32'(n_init), 32'd1);
          chk("write_pulses", 32'(n_wr), 32'd25);
          chk("read_cycles", 32'(n_rd), 32'd50);
          chk("write_order", 32'(n_ord), 32'd0);
          chk("strobe_exclusive", 32'(n_excl), 32'd0);
          chk("index_range", 32'(n_idx), 32'd0);
        end
      end
    end
  end

  // mode 0: plain run, 1: extra start in cycle 20, 2: reset in cycle 30
  task automatic run(input logic [24:0] l, input logic [24:0] k, input logic [24:0] er,
                     input logic ee, input logic [24:0] em, input logic inj, input int mode);
    exp_t e;
    int t;
    inject = inj;
    line_in_i = l;
    key_in_i = k;
    e.res = er; e.err = ee; e.mem = em;
    if (mode != 2) sb.push_back(e);
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    chk("cycle1_init", 32'(mem_init_o), 32'd1);
    chk("cycle1_busy", 32'(busy_o), 32'd1);
    chk("cycle1_error_clear", 32'(error_o), 32'd0);
    if (mode == 1) begin
      repeat (19) @(negedge clk_i);
      start_i = 1'b1; line_in_i = ~l; key_in_i = ~k;
      @(negedge clk_i);
      start_i = 1'b0; line_in_i = l; key_in_i = k;
    end
    if (mode == 2) begin
      repeat (29) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("rst_mid_ctrl", {25'd0, busy_o, done_o, error_o, mem_init_o, mem_write_o,
                           mem_read_o, mem_val_o}, 32'd0);
      chk("rst_mid_index", 32'(mem_index_o), 32'd0);
      chk("rst_mid_line", 32'(mem_line_o), 32'd0);
      chk("rst_mid_result", 32'(result_o), 32'd0);
      @(negedge clk_i) rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
    end else begin
      t = 0;
      while (!done_o && t < 200) begin
        @(negedge clk_i);
        t++;
      end
      if (!done_o) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk_i);
      chk("result_hold", 32'(result_o), 32'(er));
      chk("idle_after_done", 32'(busy_o | done_o), 32'd0);
    end
    inject = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; line_in_i = '0; key_in_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_ctrl", {25'd0, busy_o, done_o, error_o, mem_init_o, mem_write_o,
                       mem_read_o, mem_val_o}, 32'd0);
    chk("reset_result", 32'(result_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    run(25'h1ABCDEF, 25'h0000000, 25'h1ABCDEF, 1'b0, 25'h1ABCDEF, 1'b0, 0);
    run(25'h1555555, 25'h1FFFFFF, 25'h0AAAAAA, 1'b0, 25'h0AAAAAA, 1'b0, 0);
    run(25'h0F0F0F0, 25'h1234567, 25'h1D3B597, 1'b0, 25'h1D3B597, 1'b0, 1);
    run(25'h0F0F0F0, 25'h1234567, 25'h0000000, 1'b0, 25'h0000000, 1'b0, 2);
    run(25'h1FFFFFF, 25'h0000F0F, 25'h1FFF0F0, 1'b0, 25'h1FFF0F0, 1'b0, 0);
    run(25'h0123456, 25'h1000001, 25'h11234D7, 1'b1, 25'h1123457, 1'b1, 0);
    run(25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 25'h1FFFFFF, 1'b0, 0);
    repeat (5) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
